// File: rtl/sap_pkg.sv
// Shared definitions for the SAP program sequencer: state encoding and
// default geometry of the program RAM and CPU clear ring.
package sap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR,
    ST_RUN,
    ST_HALT
  } seq_state_e;

  localparam int DEF_ADDR_W     = 4;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_CLR_CYCLES = 6;

endpackage

// File: rtl/sap_sat_counter.sv
// Up-counter with synchronous clear, count enable and saturation at MAX.
module sap_sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/sap_prog_sequencer.sv
// Sequencer that loads a program into the SAP RAM from a host stream,
// holds the CPU in clear, lets it run and parks it on HLT or abort.
module sap_prog_sequencer
  import sap_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CLR_CYCLES = DEF_CLR_CYCLES,
  parameter int RUNCNT_W   = 16
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                start_load,
  input  logic                start_run,
  input  logic                abort,
  input  logic                hst_valid,
  output logic                hst_ready,
  input  logic [ADDR_W-1:0]   hst_addr,
  input  logic [DATA_W-1:0]   hst_data,
  input  logic                hst_last,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic                cpu_hlt,
  output logic                cpu_clr,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic                busy,
  output logic                halted,
  output logic [ADDR_W:0]     load_cnt,
  output logic [RUNCNT_W-1:0] run_cycles
);

  localparam int                CNT_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CLR_LAST = CNT_W'(CLR_CYCLES - 1);
  localparam logic [ADDR_W:0]   LOAD_MAX = {1'b1, {ADDR_W{1'b0}}};

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  clrCnt_q, clrCnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              hstFire;
  logic              loadEnter;
  logic              clearEnter;

  assign hstFire    = (state_q == ST_LOAD) && hst_valid;
  assign loadEnter  = (state_d == ST_LOAD) && (state_q != ST_LOAD);
  assign clearEnter = (state_d == ST_CLEAR) && (state_q != ST_CLEAR);

  always_comb begin
    state_d  = state_q;
    clrCnt_d = clrCnt_q;
    we_d     = hstFire;
    waddr_d  = hstFire ? hst_addr : waddr_q;
    wdata_d  = hstFire ? hst_data : wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (start_load)      state_d = ST_LOAD;
        else if (start_run)  state_d = ST_CLEAR;
      end
      ST_LOAD: begin
        if (abort)                     state_d = ST_IDLE;
        else if (hstFire && hst_last)  state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (abort)                     state_d = ST_IDLE;
        else if (clrCnt_q == CLR_LAST) state_d = ST_RUN;
        else                           clrCnt_d = clrCnt_q + 1'b1;
      end
      ST_RUN: begin
        // abort is checked first so it wins over a simultaneous HLT
        if (abort)         state_d = ST_IDLE;
        else if (cpu_hlt)  state_d = ST_HALT;
      end
      ST_HALT: begin
        if (start_load)      state_d = ST_LOAD;
        else if (start_run)  state_d = ST_CLEAR;
      end
      default: state_d = ST_IDLE;
    endcase
    if (clearEnter) clrCnt_d = '0;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= ST_IDLE;
      clrCnt_q <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      clrCnt_q <= clrCnt_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  sap_sat_counter #(
    .WIDTH (ADDR_W + 1),
    .MAX   (LOAD_MAX)
  ) u_loadCnt (
    .clk     (clk),
    .rst_n   (clr_n),
    .clear_i (loadEnter),
    .en_i    (hstFire),
    .count_o (load_cnt)
  );

  sap_sat_counter #(
    .WIDTH (RUNCNT_W),
    .MAX   ({RUNCNT_W{1'b1}})
  ) u_runCnt (
    .clk     (clk),
    .rst_n   (clr_n),
    .clear_i (clearEnter),
    .en_i    (state_q == ST_RUN),
    .count_o (run_cycles)
  );

  assign hst_ready = (state_q == ST_LOAD);
  assign cpu_clr   = (state_q != ST_RUN);
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted    = (state_q == ST_HALT);
  assign ram_we    = we_q;
  assign ram_addr  = (state_q == ST_RUN) ? cpu_addr : waddr_q;
  assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_sap_prog_sequencer.sv
// Scoreboard bench for sap_prog_sequencer: host writes are queued as they
// are issued and a monitor matches every ram_we pulse against the queue.
module tb_sap_prog_sequencer;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        start_load = 1'b0;
  logic        start_run = 1'b0;
  logic        abort = 1'b0;
  logic        hst_valid = 1'b0;
  logic        hst_ready;
  logic [3:0]  hst_addr = '0;
  logic [7:0]  hst_data = '0;
  logic        hst_last = 1'b0;
  logic [3:0]  cpu_addr = '0;
  logic        cpu_hlt = 1'b0;
  logic        cpu_clr;
  logic        ram_we;
  logic [3:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic        busy;
  logic        halted;
  logic [4:0]  load_cnt;
  logic [15:0] run_cycles;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t expQ[$];
  int  checks = 0;
  int  errors = 0;
  int  weCount = 0;
  int  expWrites = 0;
  int  clrLen;
  int  runLen;
  logic [3:0] lastAddr;

  sap_prog_sequencer dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .start_load (start_load),
    .start_run  (start_run),
    .abort      (abort),
    .hst_valid  (hst_valid),
    .hst_ready  (hst_ready),
    .hst_addr   (hst_addr),
    .hst_data   (hst_data),
    .hst_last   (hst_last),
    .cpu_addr   (cpu_addr),
    .cpu_hlt    (cpu_hlt),
    .cpu_clr    (cpu_clr),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .busy       (busy),
    .halted     (halted),
    .load_cnt   (load_cnt),
    .run_cycles (run_cycles)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every ram_we cycle must match the oldest outstanding host write
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      weCount++;
      if (expQ.size() == 0) begin
        checkOutput("we_unexpected", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        checkOutput("we_addr", 32'(ram_addr), 32'(e.addr));
        checkOutput("we_data", 32'(ram_wdata), 32'(e.data));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [7:0] d, input logic last);
    hst_valid = 1'b1;
    hst_addr  = a;
    hst_data  = d;
    hst_last  = last;
    expQ.push_back('{addr: a, data: d});
    expWrites++;
    lastAddr = a;
    tick();
    hst_valid = 1'b0;
    hst_last  = 1'b0;
    if (!last) repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic pulseStart(input logic ld, input logic rn);
    start_load = ld;
    start_run  = rn;
    tick();
    start_load = 1'b0;
    start_run  = 1'b0;
  endtask

  // Counts cpu_clr-high cycles from inside CLEAR; leaves us at RUN cycle 1 negedge
  task automatic waitClear(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cpu_clr === 1'b0) break;
      n++;
    end
  endtask

  // Starting at the negedge of RUN cycle 1, raise HLT during RUN cycle n
  task automatic runUntilHalt(input int n);
    for (int c = 1; c < n; c++) begin
      @(posedge clk);
      #1;
      cpu_addr = 4'($urandom);
      #1;
      checkOutput("ram_addr_follow", 32'(ram_addr), 32'(cpu_addr));
    end
    cpu_hlt = 1'b1;
    tick();
    cpu_hlt = 1'b0;
  endtask

  task automatic checkReset();
    checkOutput("rst_cpu_clr", 32'(cpu_clr), 32'd1);
    checkOutput("rst_hst_ready", 32'(hst_ready), 32'd0);
    checkOutput("rst_ram_we", 32'(ram_we), 32'd0);
    checkOutput("rst_ram_addr", 32'(ram_addr), 32'd0);
    checkOutput("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    checkOutput("rst_load_cnt", 32'(load_cnt), 32'd0);
    checkOutput("rst_run_cycles", 32'(run_cycles), 32'd0);
  endtask

  initial begin
    logic [3:0] a;
    logic [7:0] d;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkReset();
    clr_n = 1'b1;
    tick();

    // Three-word program, then clear ring and run
    pulseStart(1'b1, 1'b0);
    checkOutput("load_ready", 32'(hst_ready), 32'd1);
    checkOutput("load_busy", 32'(busy), 32'd1);
    checkOutput("load_cnt_entry", 32'(load_cnt), 32'd0);
    pulseStart(1'b0, 1'b1);
    checkOutput("load_ignores_run", 32'(hst_ready), 32'd1);
    applyStimulus(4'h0, 8'h09, 1'b0);
    applyStimulus(4'h1, 8'h1A, 1'b0);
    applyStimulus(4'h2, 8'hEF, 1'b1);
    checkOutput("load_cnt_3", 32'(load_cnt), 32'd3);
    checkOutput("clear_no_ready", 32'(hst_ready), 32'd0);
    waitClear(clrLen);
    checkOutput("clear_len", 32'(clrLen), 32'd6);
    checkOutput("run_busy", 32'(busy), 32'd1);
    checkOutput("run_no_ready", 32'(hst_ready), 32'd0);
    checkOutput("run_no_we", 32'(ram_we), 32'd0);
    cpu_addr = 4'h5;
    #1;
    checkOutput("ram_addr_cpu5", 32'(ram_addr), 32'h5);
    runUntilHalt(30);
    @(negedge clk);
    checkOutput("halt_run_cycles", 32'(run_cycles), 32'd30);
    checkOutput("halt_halted", 32'(halted), 32'd1);
    checkOutput("halt_cpu_clr", 32'(cpu_clr), 32'd1);
    checkOutput("halt_busy", 32'(busy), 32'd0);
    checkOutput("halt_ram_addr", 32'(ram_addr), 32'(lastAddr));
    repeat (3) tick();
    checkOutput("halt_frozen", 32'(run_cycles), 32'd30);

    // Restart; simultaneous HLT and abort in RUN cycle 1
    pulseStart(1'b0, 1'b1);
    checkOutput("clear_resets_run", 32'(run_cycles), 32'd0);
    waitClear(clrLen);
    checkOutput("clear_len2", 32'(clrLen), 32'd6);
    cpu_hlt = 1'b1;
    abort   = 1'b1;
    tick();
    cpu_hlt = 1'b0;
    abort   = 1'b0;
    checkOutput("abort_halted", 32'(halted), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_cpu_clr", 32'(cpu_clr), 32'd1);
    checkOutput("abort_run_cycles", 32'(run_cycles), 32'd1);

    // 18 random words; load_cnt saturates at 16
    pulseStart(1'b1, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      a = 4'($urandom);
      d = 8'($urandom);
      applyStimulus(a, d, (k == 18));
      checkOutput("load_cnt_sat", 32'(load_cnt), 32'((k < 16) ? k : 16));
    end
    // Abort during CLEAR while the last write is still on the RAM port
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("clear_abort_busy", 32'(busy), 32'd0);
    checkOutput("clear_abort_cnt", 32'(load_cnt), 32'd16);

    // Random run length, then both starts in HALT go to LOAD
    pulseStart(1'b0, 1'b1);
    waitClear(clrLen);
    checkOutput("clear_len3", 32'(clrLen), 32'd6);
    runLen = int'($urandom_range(5, 20));
    runUntilHalt(runLen);
    @(negedge clk);
    checkOutput("halt_run_rand", 32'(run_cycles), 32'(runLen));
    checkOutput("halt_halted2", 32'(halted), 32'd1);
    tick();
    pulseStart(1'b1, 1'b1);
    checkOutput("halt_prio_ready", 32'(hst_ready), 32'd1);
    checkOutput("halt_prio_busy", 32'(busy), 32'd1);
    checkOutput("halt_prio_cnt", 32'(load_cnt), 32'd0);
    applyStimulus(4'($urandom), 8'($urandom), 1'b0);
    applyStimulus(4'($urandom), 8'($urandom), 1'b0);
    repeat (2) tick();

    // Reset right after a handshake: the pending write must vanish
    hst_valid = 1'b1;
    hst_addr  = 4'hC;
    hst_data  = 8'h5A;
    tick();
    clr_n     = 1'b0;
    hst_valid = 1'b0;
    @(negedge clk);
    checkReset();
    tick();
    clr_n = 1'b1;
    repeat (3) tick();

    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    checkOutput("we_pulses", 32'(weCount), 32'(expWrites));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
